// File: rtl/quant_scaler_if.sv
// Stream bus for quant_scaler: input beat handshake, output beat handshake
// and saturation statistics. clock/reset stay as plain module ports.
interface quant_scaler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int GAIN_WIDTH = 32,
    parameter int CHANNELS   = 2
);
    logic [CHANNELS*DATA_WIDTH-1:0] in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic [1:0]                     mode;
    logic [GAIN_WIDTH-1:0]          gain;
    logic [CHANNELS*DATA_WIDTH-1:0] out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [CHANNELS-1:0]            out_sat;
    logic [15:0]                    sat_count;
    logic                           sat_clear;

    modport master (
        output in_data, in_valid, mode, gain, out_ready, sat_clear,
        input  in_ready, out_data, out_valid, out_sat, sat_count
    );

    modport slave (
        input  in_data, in_valid, mode, gain, out_ready, sat_clear,
        output in_ready, out_data, out_valid, out_sat, sat_count
    );
endinterface

// File: rtl/quant_scaler.sv
// Multi-lane fixed-point quantize / dequantize / scale / pass-through stage.
// Two register stages: S1 captures the beat and forms the wide product,
// S2 applies the toward-zero shift and clamps each lane to DATA_WIDTH.
module quant_scaler #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter int CHANNELS   = 2,
    parameter int GAIN_WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    quant_scaler_if.slave bus
);
    localparam int PW = DATA_WIDTH + GAIN_WIDTH;

    localparam logic [1:0] MODE_QUANT   = 2'b00;
    localparam logic [1:0] MODE_DEQUANT = 2'b01;
    localparam logic [1:0] MODE_SCALE   = 2'b10;
    localparam logic [1:0] MODE_PASS    = 2'b11;

    localparam logic signed [PW-1:0] SAT_MAX  = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN  = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    // Added to negative values before the arithmetic shift so it truncates toward zero.
    localparam logic signed [PW-1:0] RND_BIAS = {{(PW-BITS){1'b0}}, {BITS{1'b1}}};

    logic                           w_s1_load;
    logic                           w_s2_adv;
    logic                           w_in_xfer;
    logic                           w_out_xfer;
    logic signed [PW-1:0]           w_gain_ext;
    logic signed [PW-1:0]           w_lane_ext [CHANNELS];
    logic signed [PW-1:0]           w_prod     [CHANNELS];
    logic signed [PW-1:0]           w_sum      [CHANNELS];
    logic signed [PW-1:0]           w_rnd      [CHANNELS];
    logic [CHANNELS*DATA_WIDTH-1:0] w_res;
    logic [CHANNELS-1:0]            w_sat;

    logic                           r_s1_valid;
    logic [1:0]                     r_s1_mode;
    logic signed [PW-1:0]           r_s1_prod  [CHANNELS];
    logic                           r_s2_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] r_out_data;
    logic [CHANNELS-1:0]            r_out_sat;
    logic [15:0]                    r_sat_count;

    // S2 moves when empty or its beat leaves; S1 loads when empty or its beat moves to S2.
    assign w_s2_adv   = !r_s2_valid || bus.out_ready;
    assign w_s1_load  = !r_s1_valid || w_s2_adv;
    assign w_in_xfer  = bus.in_valid && w_s1_load;
    assign w_out_xfer = r_s2_valid && bus.out_ready;

    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign bus.sat_count = r_sat_count;

    // S1 datapath: sign-extend each lane and form the full-precision product.
    always_comb begin
        w_gain_ext = $signed(bus.gain);
        for (int c = 0; c < CHANNELS; c++) begin
            w_lane_ext[c] = $signed(bus.in_data[c*DATA_WIDTH +: DATA_WIDTH]);
            w_prod[c]     = w_lane_ext[c];
            case (bus.mode)
                MODE_QUANT:             w_prod[c] = w_lane_ext[c] <<< BITS;
                MODE_SCALE:             w_prod[c] = w_lane_ext[c] * w_gain_ext;
                MODE_DEQUANT, MODE_PASS: w_prod[c] = w_lane_ext[c];
                default:                w_prod[c] = w_lane_ext[c];
            endcase
        end
    end

    // S2 datapath: toward-zero shift for DEQUANTIZE/SCALE, then per-lane clamp.
    always_comb begin
        w_res = '0;
        w_sat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_sum[c] = r_s1_prod[c];
            if (r_s1_prod[c][PW-1]) begin
                w_sum[c] = r_s1_prod[c] + RND_BIAS;
            end
            w_rnd[c] = r_s1_prod[c];
            if (r_s1_mode == MODE_DEQUANT || r_s1_mode == MODE_SCALE) begin
                w_rnd[c] = w_sum[c] >>> BITS;
            end
            if (w_rnd[c] > SAT_MAX) begin
                w_res[c*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
                w_sat[c] = 1'b1;
            end else if (w_rnd[c] < SAT_MIN) begin
                w_res[c*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
                w_sat[c] = 1'b1;
            end else begin
                w_res[c*DATA_WIDTH +: DATA_WIDTH] = w_rnd[c][DATA_WIDTH-1:0];
            end
        end
    end

    // S1 register: capture mode and products with each accepted beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= MODE_QUANT;
            for (int c = 0; c < CHANNELS; c++) begin
                r_s1_prod[c] <= '0;
            end
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_in_xfer) begin
                r_s1_mode <= bus.mode;
                for (int c = 0; c < CHANNELS; c++) begin
                    r_s1_prod[c] <= w_prod[c];
                end
            end
        end
    end

    // S2 register: clamped results, held stable while downstream stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_res;
                r_out_sat  <= w_sat;
            end
        end
    end

    // Saturated-beat counter; clear wins over a same-cycle increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sat_count <= '0;
        end else if (bus.sat_clear) begin
            r_sat_count <= '0;
        end else if (w_out_xfer && (|r_out_sat) && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_quant_scaler.sv
// Directed bench for quant_scaler with BITS=10, DATA_WIDTH=32, CHANNELS=2.
module tb_quant_scaler;
    localparam int DW = 32;
    localparam int GW = 32;
    localparam int CH = 2;
    localparam int BT = 10;

    localparam logic [1:0] M_QUANT   = 2'b00;
    localparam logic [1:0] M_DEQUANT = 2'b01;
    localparam logic [1:0] M_SCALE   = 2'b10;
    localparam logic [1:0] M_PASS    = 2'b11;

    logic clock;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    quant_scaler_if #(.DATA_WIDTH(DW), .GAIN_WIDTH(GW), .CHANNELS(CH)) qs_if ();

    quant_scaler #(
        .DATA_WIDTH (DW),
        .BITS       (BT),
        .CHANNELS   (CH),
        .GAIN_WIDTH (GW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (qs_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int l0, input int l1);
        return {l1, l0};
    endfunction

    // Send one beat with out_ready high; check 2-cycle latency and the result.
    task automatic beat(input string tag, input logic [1:0] m, input logic [31:0] g,
                        input int l0, input int l1,
                        input logic [63:0] ed, input logic [1:0] es);
        int n;
        @(negedge clock);
        qs_if.in_data   = pack(l0, l1);
        qs_if.mode      = m;
        qs_if.gain      = g;
        qs_if.in_valid  = 1'b1;
        qs_if.out_ready = 1'b1;
        #1;
        n = 0;
        while (!qs_if.in_ready && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= 20) chk({tag, "_rdy_timeout"}, 64'(qs_if.in_ready), 64'd1);
        @(posedge clock);
        #1;
        qs_if.in_valid = 1'b0;
        chk({tag, "_lat"}, 64'(qs_if.out_valid), 64'd0);
        @(posedge clock);
        #1;
        chk({tag, "_vld"}, 64'(qs_if.out_valid), 64'd1);
        chk({tag, "_dat"}, qs_if.out_data, ed);
        chk({tag, "_sat"}, 64'(qs_if.out_sat), 64'(es));
    endtask

    initial begin
        int  ii;
        int  io;
        bit  stall;
        bit  hold_chk;
        bit  acc_in;
        bit  acc_out;
        logic [63:0] held;
        logic [63:0] cur;

        reset_n         = 1'b0;
        qs_if.in_data   = '0;
        qs_if.in_valid  = 1'b0;
        qs_if.mode      = M_PASS;
        qs_if.gain      = '0;
        qs_if.out_ready = 1'b1;
        qs_if.sat_clear = 1'b0;
        #1;
        chk("rst_vld", 64'(qs_if.out_valid), 64'd0);
        chk("rst_dat", qs_if.out_data, 64'd0);
        chk("rst_sat", 64'(qs_if.out_sat), 64'd0);
        chk("rst_cnt", 64'(qs_if.sat_count), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_rdy", 64'(qs_if.in_ready), 64'd1);

        beat("quant",  M_QUANT,   32'd0,    3,    -5,    pack(3072, -5120), 2'b00);
        beat("deq_a",  M_DEQUANT, 32'd0,    -1,   -1025, pack(0, -1),       2'b00);
        beat("deq_b",  M_DEQUANT, 32'd0,    2047, 1024,  pack(1, 1),        2'b00);
        beat("scl_a",  M_SCALE,   32'd758,  1024, -2048, pack(758, -1516),  2'b00);
        beat("scl_b",  M_SCALE,   32'd1024, 7,    -7,    pack(7, -7),       2'b00);
        beat("scl_h",  M_SCALE,   32'd512,  3,    -3,    pack(1, -1),       2'b00);
        beat("pass",   M_PASS,    32'd0,    123,  -456,  pack(123, -456),   2'b00);

        beat("qsat",   M_QUANT,   32'd0,    2097152, -2097153, 64'h80000000_7FFFFFFF, 2'b11);
        @(posedge clock);
        #1;
        chk("qsat_cnt", 64'(qs_if.sat_count), 64'd1);
        @(negedge clock);
        qs_if.sat_clear = 1'b1;
        @(posedge clock);
        #1;
        qs_if.sat_clear = 1'b0;
        chk("clr_cnt", 64'(qs_if.sat_count), 64'd0);

        beat("qsat2",  M_QUANT,   32'd0,    -2097153, 2097152, 64'h7FFFFFFF_80000000, 2'b11);
        @(negedge clock);
        qs_if.sat_clear = 1'b1;
        @(posedge clock);
        #1;
        qs_if.sat_clear = 1'b0;
        chk("clr_inc_cnt", 64'(qs_if.sat_count), 64'd0);

        beat("lane",   M_SCALE,   32'h0010_0000, 4194304, 1, {32'd1024, 32'h7FFFFFFF}, 2'b01);
        @(posedge clock);
        #1;
        chk("lane_cnt", 64'(qs_if.sat_count), 64'd1);

        // Stream with a 3-cycle downstream stall in the middle.
        ii = 0; io = 0; stall = 0; hold_chk = 0; held = '0;
        for (int cyc = 0; cyc < 60 && io < 8; cyc++) begin
            @(negedge clock);
            qs_if.out_ready = !(cyc >= 4 && cyc < 7);
            qs_if.in_valid  = (ii < 8);
            qs_if.mode      = M_PASS;
            qs_if.in_data   = pack(100 + ii, -100 - ii);
            #1;
            if (!qs_if.in_ready) stall = 1;
            if (hold_chk) chk("strm_hold", qs_if.out_data, held);
            hold_chk = qs_if.out_valid && !qs_if.out_ready;
            held     = qs_if.out_data;
            acc_in   = qs_if.in_valid && qs_if.in_ready;
            acc_out  = qs_if.out_valid && qs_if.out_ready;
            cur      = qs_if.out_data;
            if (acc_out) begin
                chk("strm_dat", cur, pack(100 + io, -100 - io));
                io++;
            end
            @(posedge clock);
            if (acc_in) ii++;
        end
        qs_if.in_valid  = 1'b0;
        qs_if.out_ready = 1'b1;
        chk("strm_num", 64'(io), 64'd8);
        chk("strm_stall", 64'(stall), 64'd1);
        @(negedge clock);
        chk("strm_dup", 64'(qs_if.out_valid), 64'd0);
        chk("strm_cnt", 64'(qs_if.sat_count), 64'd1);

        // Reset with two beats in flight.
        @(negedge clock);
        qs_if.out_ready = 1'b0;
        qs_if.in_valid  = 1'b1;
        qs_if.mode      = M_QUANT;
        qs_if.in_data   = pack(1, 2);
        @(posedge clock);
        #1;
        qs_if.in_data = pack(3, 4);
        @(posedge clock);
        #1;
        qs_if.in_valid = 1'b0;
        chk("mid_pre_vld", 64'(qs_if.out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_vld", 64'(qs_if.out_valid), 64'd0);
        chk("mid_cnt", 64'(qs_if.sat_count), 64'd0);
        chk("mid_dat", qs_if.out_data, 64'd0);
        @(negedge clock);
        reset_n         = 1'b1;
        qs_if.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("mid_idle", 64'(qs_if.out_valid), 64'd0);
        beat("fresh", M_QUANT, 32'd0, 1, -1, pack(1024, -1024), 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
